// File: rtl/insn_frame_loader.sv
// Purpose : stages a 16-instruction frame from the scheduler's beat stream into a
//           local buffer, then serves core fetches from it until the core halts.
// Latency : run_start 1 cycle after the last beat capture; fetch_insn 1 cycle after fetch_en.
// Backpressure: ready=0 while the core runs a frame; the scheduler gates start on ready.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, load_cnt       beat strobe and beat index from the scheduler
//   insn_data             beat payload, instruction 0 in the LSBs
//   init_r0_en, init_r0   R0 initial value, latched with beat 0
//   ready                 idle / accepting a frame
//   run_start             one-cycle pulse: frame loaded, core starts at pc 0
//   r0_wr, r0_val         R0 initialisation qualifier and value (with run_start)
//   fetch_en, fetch_pc    core fetch request and instruction index
//   fetch_insn            registered fetched instruction
//   halt                  core finished the frame
//   load_err              sticky beat-sequence error
//
// Build option: define INSN_LOADER_CHECK_EN to track the expected beat index and
// flag out-of-order beats on load_err (frame discarded). Undefined, load_cnt is
// trusted as the write index and load_err is tied low.

module insn_frame_loader #(
  parameter  int INSN_WIDTH     = 16,
  parameter  int INSNS_PER_PART = 4,
  parameter  int LOAD_TIME      = 4,
  parameter  int REG_WIDTH      = 8,
  localparam int CNT_W          = (LOAD_TIME > 1) ? $clog2(LOAD_TIME) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CNT_W-1:0]                   load_cnt,
  input  logic [INSN_WIDTH*INSNS_PER_PART-1:0] insn_data,
  input  logic                               init_r0_en,
  input  logic [REG_WIDTH-1:0]               init_r0,
  output logic                               ready,
  output logic                               run_start,
  output logic                               r0_wr,
  output logic [REG_WIDTH-1:0]               r0_val,
  input  logic                               fetch_en,
  input  logic [3:0]                         fetch_pc,
  output logic [INSN_WIDTH-1:0]              fetch_insn,
  input  logic                               halt,
  output logic                               load_err
);

  localparam int FRAME = LOAD_TIME * INSNS_PER_PART;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state;
  logic   r0_pend;
  logic   beat_ok;
  logic   cap_en;

  logic [FRAME-1:0][INSN_WIDTH-1:0] frame_rd;

`ifdef INSN_LOADER_CHECK_EN
  logic [CNT_W-1:0] exp_cnt;
`endif

  // A beat is accepted in IDLE only if it opens a frame; in LOAD either the
  // tracked index must match, or the scheduler's index is taken as-is.
  always_comb begin
    beat_ok = 1'b0;
    case (state)
      ST_IDLE: beat_ok = (load_cnt == '0);
`ifdef INSN_LOADER_CHECK_EN
      ST_LOAD: beat_ok = (load_cnt == exp_cnt);
`else
      ST_LOAD: beat_ok = 1'b1;
`endif
      default: beat_ok = 1'b0;
    endcase
  end

  assign cap_en = start && beat_ok;

  // ready is a pure decode of the state register, so it is glitch-free and
  // stays high through the capture cycle of the final beat.
  assign ready = (state != ST_RUN);

  // Instruction buffer: one register per slot, no reset. It can only be read
  // in RUN, which is reachable only through a completed load, so stale
  // contents after reset are never exposed.
  for (genvar s = 0; s < FRAME; s++) begin : g_slot
    logic [INSN_WIDTH-1:0] slot_q;

    always_ff @(posedge clk) begin
      if (cap_en && (load_cnt == CNT_W'(s / INSNS_PER_PART))) begin
        slot_q <= insn_data[(s % INSNS_PER_PART)*INSN_WIDTH +: INSN_WIDTH];
      end
    end

    assign frame_rd[s] = slot_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      run_start  <= 1'b0;
      r0_wr      <= 1'b0;
      r0_val     <= '0;
      r0_pend    <= 1'b0;
      fetch_insn <= '0;
`ifdef INSN_LOADER_CHECK_EN
      exp_cnt    <= '0;
      load_err   <= 1'b0;
`endif
    end else begin
      run_start <= 1'b0;
      r0_wr     <= 1'b0;

      case (state)
        ST_IDLE, ST_LOAD: begin
          if (cap_en) begin
            if (load_cnt == '0) begin
              r0_val  <= init_r0;
              r0_pend <= init_r0_en;
            end
            if (load_cnt == LAST_CNT) begin
              state     <= ST_RUN;
              run_start <= 1'b1;
              // With a single-beat frame the pending flag is being written
              // this same cycle, so take it straight from the input.
              r0_wr     <= (load_cnt == '0) ? init_r0_en : r0_pend;
            end else begin
              state <= ST_LOAD;
            end
`ifdef INSN_LOADER_CHECK_EN
            exp_cnt <= load_cnt + 1'b1;
`endif
          end
`ifdef INSN_LOADER_CHECK_EN
          else if (start) begin
            // Out-of-sequence beat: drop the partial frame.
            load_err <= 1'b1;
            state    <= ST_IDLE;
          end
`endif
        end

        ST_RUN: begin
          if (fetch_en) begin
            fetch_insn <= frame_rd[fetch_pc];
          end
          if (halt) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef INSN_LOADER_CHECK_EN
  assign load_err = 1'b0;
`endif

endmodule

// File: doc/insn_frame_loader.md
INSN_FRAME_LOADER -- requirements
Module: insn_frame_loader

Interface
REQ-001 Parameter INSN_WIDTH, 16, bits per instruction.
REQ-002 Parameter INSNS_PER_PART, 4, instructions per Insn_Data beat.
REQ-003 Parameter LOAD_TIME, 4, beats per instruction frame; frame = LOAD_TIME*INSNS_PER_PART = 16 instructions.
REQ-004 Parameter REG_WIDTH, 8, width of R0.
REQ-005 clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  this core's bit of the scheduler Start vector.
REQ-007 load_cnt  input  clog2(LOAD_TIME)  scheduler Insn_Load_Counter, the beat index.
REQ-008 insn_data  input  INSN_WIDTH*INSNS_PER_PART  beat payload, instruction 0 in LSBs.
REQ-009 init_r0_en  input  1  this core's bit of Init_R0_Vect.
REQ-010 init_r0  input  REG_WIDTH  this core's slice of Init_R0.
REQ-011 ready  output  1  to scheduler, core idle / accepting a frame.
REQ-012 run_start  output  1  one-cycle pulse, frame loaded, core begins at pc 0.
REQ-013 r0_wr  output  1  qualifies r0_val during run_start.
REQ-014 r0_val  output  REG_WIDTH  captured R0 initial value.
REQ-015 fetch_en  input  1  core fetch request; fetch_pc  input  4  instruction index.
REQ-016 fetch_insn  output  INSN_WIDTH  registered instruction, valid one cycle after fetch_en.
REQ-017 halt  input  1  core finished the frame.
REQ-018 load_err  output  1  sticky sequence error (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, LOAD and RUN; ready = 1 in IDLE and LOAD, 0 in RUN.
REQ-020 IDLE: start=1 with load_cnt=0 SHALL write beat 0 into buffer slots 0..INSNS_PER_PART-1 and go to LOAD, or directly to RUN when LOAD_TIME=1.
REQ-021 The cnt=0 beat SHALL also latch r0_val<=init_r0 and r0_pend<=init_r0_en.
REQ-022 LOAD: each cycle with start=1 SHALL write beat load_cnt into slots load_cnt*INSNS_PER_PART and up.
REQ-023 Writing beat LOAD_TIME-1 SHALL move the FSM to RUN next cycle. ready stays 1 through that capture cycle, because the scheduler gates Start on ready.
REQ-024 start=0 in LOAD SHALL hold state and buffer; capture resumes when start returns.
REQ-025 First cycle in RUN: run_start=1 for exactly one cycle, r0_wr=r0_pend in the same cycle, then both 0.
REQ-026 RUN: fetch_en SHALL register buffer[fetch_pc] onto fetch_insn next cycle. fetch_insn holds its last value otherwise. fetch_en outside RUN is ignored.
REQ-027 RUN: halt=1 SHALL move to IDLE next cycle (ready=1). A fetch in the halt cycle is still served.
REQ-028 start in RUN SHALL be ignored. halt in IDLE/LOAD SHALL be ignored.
REQ-029 Load-to-run latency: run_start asserts exactly 1 cycle after the last beat capture.
REQ-030 Consecutive frames SHALL overwrite the buffer fully; no state is carried between frames except r0_val.

Reset
REQ-031 reset SHALL force IDLE, ready=1, run_start=0, r0_wr=0, r0_val=0, r0_pend=0, fetch_insn=0, load_err=0, from any state including mid-LOAD and mid-RUN.
REQ-032 Buffer contents are not cleared by reset and SHALL NOT be observable before the next completed load.

Configuration
REQ-033 Macro INSN_LOADER_CHECK_EN defined: the block tracks the expected beat index. A start beat whose load_cnt differs from it (including cnt!=0 in IDLE) SHALL set load_err sticky until reset, discard the frame and return to IDLE with ready=1.
REQ-034 Macro undefined: load_cnt is trusted as the write index, a cnt!=0 beat in IDLE is ignored, and load_err is constant 0.

Verification
REQ-035 Load frame, beats 0..3 on consecutive cycles, insn i = 16'h1000+i, init_r0_en=1, init_r0=8'hA5 -> ready high through the beat-3 cycle, run_start and r0_wr=1 with r0_val=A5 one cycle later, fetch pc 0..15 returns 1000..100F.
REQ-036 Beats 0,1, then start low 3 cycles, then beats 2,3 -> state stays LOAD, run_start one cycle after beat 3, data intact.
REQ-037 In RUN, assert halt with fetch_pc=5 -> fetch_insn=1005 next cycle, ready=1, and a following start burst with init_r0_en=0 gives r0_wr=0.
REQ-038 reset asserted after beat 2, then a full new frame -> no run_start until the new beat 3; new data is fetched.
REQ-039 With INSN_LOADER_CHECK_EN, beats 0,2 -> load_err=1 sticky, IDLE, no run_start. Without it, same stimulus -> load_err=0 and LOAD continues.
